// File: rtl/divide_block.sv
// rtl/divide_block.sv - sequential signed restoring divider with start/done handshake
// Optional build macro: DIVIDE_SAT_EN (saturate the quotient on -2^(WIDTH-1) / -1)
module divide_block #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             divide_done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINUS_ONE = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_lat_q, a_lat_d;
  logic [WIDTH-1:0] b_lat_q, b_lat_d;
  logic [WIDTH-1:0] div_q, div_d;     // |b|
  logic [WIDTH-1:0] quo_q, quo_d;     // |a| shifting out, quotient bits shifting in
  logic [WIDTH:0]   rem_q, rem_d;     // partial remainder, one spare bit for the shift
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;

  logic [WIDTH:0]   rem_sh;
  logic             sign_a, sign_b;

  assign sign_a = a_lat_q[WIDTH-1];
  assign sign_b = b_lat_q[WIDTH-1];
  assign rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dz_q;
  assign overflow    = ov_q;
  assign busy        = (state_q != S_IDLE);
  assign divide_done = (state_q == S_DONE);

  // Next-state and datapath: a start in any state relatches operands and restarts from ABS
  always_comb begin
    state_d = state_q;
    a_lat_d = a_lat_q;
    b_lat_d = b_lat_q;
    div_d   = div_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ov_d    = ov_q;

    if (start) begin
      state_d = S_ABS;
      a_lat_d = a;
      b_lat_d = b;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_ABS: begin
          // most-negative negates to 2^(WIDTH-1), which still fits unsigned
          quo_d   = sign_a ? -a_lat_q : a_lat_q;
          div_d   = sign_b ? -b_lat_q : b_lat_q;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_ITER;
        end
        S_ITER: begin
          if (rem_sh >= {1'b0, div_q}) begin
            rem_d = rem_sh - {1'b0, div_q};
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh;
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          if (b_lat_q == '0) begin
            q_d  = '0;
            r_d  = a_lat_q;
            dz_d = 1'b1;
            ov_d = 1'b0;
          end else if ((a_lat_q == MOST_NEG) && (b_lat_q == MINUS_ONE)) begin
`ifdef DIVIDE_SAT_EN
            q_d  = MOST_POS;
`else
            q_d  = MOST_NEG;
`endif
            r_d  = '0;
            dz_d = 1'b0;
            ov_d = 1'b1;
          end else begin
            // truncation toward zero: quotient sign from xor, remainder follows dividend
            q_d  = (sign_a ^ sign_b) ? -quo_q : quo_q;
            r_d  = sign_a ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            dz_d = 1'b0;
            ov_d = 1'b0;
          end
          state_d = S_DONE;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_lat_q <= '0;
      b_lat_q <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_lat_q <= a_lat_d;
      b_lat_q <= b_lat_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: doc/divide_block.md
Name: divide_block

Overview:
Sequential signed restoring (shift-subtract) divider for the calculator datapath. It is the inverse operation of the shift-add multiplier and sits alongside it behind the same start/done handshake to the calculator FSM. It takes two two's-complement operands and produces a signed quotient and a signed remainder. It flags divide-by-zero and the single overflow case.

Parameters:
WIDTH, 8, operand/result width in bits (two's complement); counter sized to hold WIDTH.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
a  input  WIDTH  dividend, signed; latched on start
b  input  WIDTH  divisor, signed; latched on start
start  input  1  single-cycle request; sampled every cycle
q  output  WIDTH  signed quotient, registered
r  output  WIDTH  signed remainder, registered
busy  output  1  high from the cycle after start until divide_done inclusive
divide_done  output  1  one-cycle pulse; q/r/flags valid from this cycle
div_by_zero  output  1  registered; b==0 for the completed operation
overflow  output  1  registered; a==most-negative and b==-1

Behaviour:
- Reset: state IDLE, q=0, r=0, busy=0, divide_done=0, div_by_zero=0, overflow=0, internal regs 0. rst overrides start and any in-flight operation; no divide_done for an aborted operation.
- Operands: a, b and their sign bits are latched on the start edge. Later changes on a/b do not affect the running operation.
- States:
  - IDLE: wait for start.
  - ABS: magnitudes |a|, |b| computed as unsigned WIDTH bits (most-negative -> 2^(WIDTH-1), fits). Partial remainder cleared, counter=0.
  - ITER: WIDTH cycles. Each cycle: {rem,quo} shifted left 1; if rem >= |b|, then rem -= |b| and quo[0]=1.
  - FIX: sign correction and output write.
  - DONE: divide_done=1 for one cycle, then IDLE.
- Latency: start high in cycle 0 -> divide_done high in cycle WIDTH+3 (cycle 11 for WIDTH=8). Latency is fixed for all operands, including b==0.
- Sign rules: truncation toward zero. Quotient negated when sign(a)!=sign(b). Remainder takes the sign of a. Invariant: a == q*b + r when not dz and not overflow.
- Divide by zero: iterations still run but results are discarded. FIX writes q=0, r=a, div_by_zero=1, overflow=0.
- Overflow: a=-2^(WIDTH-1), b=-1. overflow=1, r=0, q set per the optional feature.
- Hold: q, r and the flags hold their values until the FIX of the next operation overwrites them. They are not cleared on start.
- Start while busy: the running operation is abandoned and the block restarts from ABS with newly latched operands. Only one divide_done is produced, for the new operation.
- Start in the DONE cycle: the pulse still completes and the new operation begins next cycle.
- busy=0 only in IDLE.

Optional Feature:
DIVIDE_SAT_EN
- Defined: the overflow case saturates, giving q=2^(WIDTH-1)-1 (127 for WIDTH=8).
- Undefined: the overflow case wraps, giving q=-2^(WIDTH-1) (0x80).
- The overflow flag asserts in both builds.

Test Plan:
1. a=100, b=7, start at cycle 0 -> divide_done only in cycle 11; q=14 (0x0E), r=2; flags 0; busy high cycles 1-11.
2. a=-100, b=7 -> q=-14 (0xF2), r=-2 (0xFE). a=100, b=-7 -> q=0xF2, r=2. a=-100, b=-7 -> q=14, r=0xFE.
3. a=55, b=0 -> div_by_zero=1, overflow=0, q=0, r=55, divide_done in cycle 11.
4. a=-128, b=-1 -> overflow=1, r=0; q=0x7F with DIVIDE_SAT_EN, q=0x80 without. a=-128, b=1 -> q=0x80, r=0, overflow=0.
5. Start 100/7 at cycle 0; change a/b at cycle 3 -> result still 14 r 2. Start 9/3 at cycle 5 -> no done in cycle 11, single done in cycle 16 with q=3, r=0.
6. rst at cycle 4 of an operation -> no divide_done; q=r=0, flags 0, busy=0 next cycle. Then start -3/2 -> q=-1 (0xFF), r=-1 (0xFF).
